amp_config_sender: RTL and testbench
====================================

// Module: amp_config_sender
// PURPOSE
//  Responder to the amplifier state controller's send_config request. Walks a
//  NUM_WORDS-entry config table and shifts each word to the amplifier over a
//  3-wire SPI-style link (ncs/sclk/sdo, mode 0, MSB first), then reports done.
//  Sits between the amp state controller and the amplifier pins.
// PARAMETERS
//  NUM_WORDS  4   config words per transfer (>=1)
//  WORD_W     16  bits per config word
//  CLK_DIV    2   clk_in cycles per sclk half-period (>=1)
// PORTS
//  clk_in           in   1   system clock
//  resetb           in   1   synchronous active-low reset
//  send_config_in   in   1   level request from state controller; rising edge starts
//  cfg_addr_out     out  AW  table index, AW=max(1,$clog2(NUM_WORDS))
//  cfg_data_in      in   WORD_W  table word at cfg_addr_out (combinational lookup)
//  ncs_out          out  1   amp chip select, active low
//  sclk_out         out  1   serial clock, idles low
//  sdo_out          out  1   serial data to amp
//  sdi_in           in   1   serial echo from amp (used only with readback)
//  busy_out         out  1   transfer in progress
//  config_done_out  out  1   all words sent; held while send_config_in high
//  cfg_error_out    out  1   readback mismatch, sticky until next start
// BEHAVIOUR
//  - Reset: ncs_out=1, sclk_out=0, sdo_out=0, cfg_addr_out=0, busy_out=0,
//    config_done_out=0, cfg_error_out=0, FSM=IDLE; edge detector primed (req_q=0).
//  - All outputs registered. States: IDLE, LOAD, SHIFT, GAP, DONE.
//  - IDLE: on send_config_in=1 & req_q=0 -> LOAD, addr=0, busy=1, error cleared.
//    Level held high after reset counts as a rising edge.
//  - LOAD (1 cycle): latch cfg_data_in into shift reg; ncs_out=0, sdo_out=MSB.
//  - SHIFT: per bit, sclk low CLK_DIV cycles then high CLK_DIV cycles; sdo
//    changes only on sclk falling edge (amp samples on rising). After WORD_W
//    bits, sclk ends low, ncs_out=1 -> GAP.
//  - GAP: ncs high 2*CLK_DIV cycles. If addr==NUM_WORDS-1 -> DONE, else addr+1,
//    -> LOAD. Address never wraps within a transfer.
//  - DONE: busy=0, config_done_out=1 until send_config_in=0 -> IDLE, done=0.
//  - Timing: rising edge sampled cycle 0 -> ncs low cycle 2; ncs low
//    2*CLK_DIV*WORD_W cycles per word; done rises 1 cycle after last GAP ends.
//  - send_config_in falls mid-transfer: finish current word + GAP, then IDLE
//    with config_done_out=0 (abort). A new rising edge restarts from addr 0.
//  - Rising edges while busy are ignored.
//  - resetb low mid-word: all outputs to reset values on next clk edge (ncs
//    deasserts immediately, no partial-word completion).
// CONFIGURATION
//  AMP_CFG_READBACK_EN defined: amp echoes the previous word on sdi_in
//    (one-word shift chain). sdi_in sampled on each sclk rising edge. After
//    NUM_WORDS words one extra all-zero flush word is sent (cfg_addr_out
//    holds NUM_WORDS-1). Received word k+1 compared to sent word k; any
//    mismatch sets cfg_error_out (sticky until next start). Done still asserts.
//  Not defined: no flush word, sdi_in ignored, cfg_error_out constant 0.
// TESTING  (NUM_WORDS=4, WORD_W=16, CLK_DIV=2)
//  - Reset then req high, table {A5A5,0F0F,1234,FFFF} -> 4 ncs-low windows of
//    64 cycles, 4-cycle gaps; decoded words match table in order; done=1.
//  - Done held, req low for 1 cycle -> done=0, IDLE; req high again -> re-run
//    from addr 0.
//  - req drops during word 1 -> word 1 completes, no word 2, done stays 0.
//  - resetb low at bit 7 of word 2 -> next edge ncs=1, sclk=0, busy=0.
//  - READBACK_EN, amp model echoing correctly -> 5 windows, cfg_error_out=0;
//    corrupt bit 3 of echoed word 2 -> cfg_error_out=1, cleared on next start.
//  - CLK_DIV=1, NUM_WORDS=1 -> single 32-cycle ncs window, done after GAP.

Source files
------------

// File: rtl/amp_config_sender.sv
// amp_config_sender
//   Answers the amp state controller's send_config request: walks a NUM_WORDS
//   config table and shifts each word to the amplifier over a 3-wire mode-0
//   SPI link (ncs/sclk/sdo, MSB first), then raises config_done_out.
//   Optional feature macro: AMP_CFG_READBACK_EN -- the amp echoes the previous
//   word on sdi_in; a trailing all-zero flush word is sent and every echo is
//   compared with the word sent before it (sticky cfg_error_out).
//   Assumes WORD_W >= 2, NUM_WORDS >= 1, CLK_DIV >= 1.
module amp_config_sender #(
    parameter int unsigned NUM_WORDS = 4,
    parameter int unsigned WORD_W    = 16,
    parameter int unsigned CLK_DIV   = 2,
    localparam int unsigned AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic              clk_in,
    input  logic              resetb,
    input  logic              send_config_in,
    output logic [AW-1:0]     cfg_addr_out,
    input  logic [WORD_W-1:0] cfg_data_in,
    output logic              ncs_out,
    output logic              sclk_out,
    output logic              sdo_out,
    input  logic              sdi_in,
    output logic              busy_out,
    output logic              config_done_out,
    output logic              cfg_error_out
);

    localparam int unsigned CW = $clog2(2 * CLK_DIV);
    localparam int unsigned BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
    // ncs stays high for GAP plus the following LOAD cycle, i.e. 2*CLK_DIV cycles
    localparam logic [CW-1:0] GAP_LAST  = CW'(2 * CLK_DIV - 2);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_W - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(NUM_WORDS - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              req_q, req_d;
    logic              abort_q, abort_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              ncs_q, ncs_d;
    logic              sclk_q, sclk_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [WORD_W-1:0] load_word_c;

`ifdef AMP_CFG_READBACK_EN
    logic              flush_q, flush_d;
    logic              first_q, first_d;
    logic [WORD_W-1:0] rx_q, rx_d;
    logic [WORD_W-1:0] cur_q, cur_d;
    logic [WORD_W-1:0] prev_q, prev_d;
`else
    logic              unused_sdi;
    assign unused_sdi = sdi_in;
`endif

    assign cfg_addr_out    = addr_q;
    assign ncs_out         = ncs_q;
    assign sclk_out        = sclk_q;
    assign sdo_out         = shift_q[WORD_W-1];
    assign busy_out        = busy_q;
    assign config_done_out = done_q;
    assign cfg_error_out   = err_q;

    // Next-state and registered-output logic for the transfer sequencer
    always_comb begin
        state_d = state_q;
        req_d   = send_config_in;
        abort_d = abort_q;
        addr_d  = addr_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        ncs_d   = ncs_q;
        sclk_d  = sclk_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
`ifdef AMP_CFG_READBACK_EN
        flush_d     = flush_q;
        first_d     = first_q;
        rx_d        = rx_q;
        cur_d       = cur_q;
        prev_d      = prev_q;
        load_word_c = flush_q ? '0 : cfg_data_in;
`else
        load_word_c = cfg_data_in;
`endif

        // A dropped request is remembered so the abort survives a re-raise
        if ((state_q == ST_LOAD || state_q == ST_SHIFT || state_q == ST_GAP) && !send_config_in) begin
            abort_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (send_config_in && !req_q) begin
                    state_d = ST_LOAD;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    abort_d = 1'b0;
`ifdef AMP_CFG_READBACK_EN
                    flush_d = 1'b0;
                    first_d = 1'b1;
`endif
                end
            end

            ST_LOAD: begin
                shift_d = load_word_c;
                ncs_d   = 1'b0;
                sclk_d  = 1'b0;
                cnt_d   = '0;
                bit_d   = '0;
                state_d = ST_SHIFT;
`ifdef AMP_CFG_READBACK_EN
                cur_d   = load_word_c;
`endif
            end

            ST_SHIFT: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
`ifdef AMP_CFG_READBACK_EN
                        rx_d   = {rx_q[WORD_W-2:0], sdi_in};
`endif
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            ncs_d   = 1'b1;
                            state_d = ST_GAP;
`ifdef AMP_CFG_READBACK_EN
                            if (!first_q && (rx_q != prev_q)) begin
                                err_d = 1'b1;
                            end
                            prev_d  = cur_q;
                            first_d = 1'b0;
`endif
                        end else begin
                            bit_d   = bit_q + BW'(1);
                            shift_d = {shift_q[WORD_W-2:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (abort_q || !send_config_in) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else if (addr_q == ADDR_LAST) begin
`ifdef AMP_CFG_READBACK_EN
                        if (!flush_q) begin
                            flush_d = 1'b1;
                            state_d = ST_LOAD;
                        end else begin
                            state_d = ST_DONE;
                        end
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        addr_d  = addr_q + AW'(1);
                        state_d = ST_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
                if (!send_config_in) begin
                    done_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                ncs_d   = 1'b1;
                sclk_d  = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // Sequencer state and output registers, synchronous active-low reset
    always_ff @(posedge clk_in) begin
        if (!resetb) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            abort_q <= 1'b0;
            addr_q  <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            ncs_q   <= 1'b1;
            sclk_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            abort_q <= abort_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            ncs_q   <= ncs_d;
            sclk_q  <= sclk_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef AMP_CFG_READBACK_EN
    // Readback tracking registers
    always_ff @(posedge clk_in) begin
        if (!resetb) begin
            flush_q <= 1'b0;
            first_q <= 1'b1;
            rx_q    <= '0;
            cur_q   <= '0;
            prev_q  <= '0;
        end else begin
            flush_q <= flush_d;
            first_q <= first_d;
            rx_q    <= rx_d;
            cur_q   <= cur_d;
            prev_q  <= prev_d;
        end
    end
`endif

endmodule

// File: tb/tb_amp_config_sender.sv
// Self-checking bench for amp_config_sender: SPI decoder / amp echo model on
// the main instance, plus a NUM_WORDS=1, CLK_DIV=1 instance.
module tb_amp_config_sender;

`ifdef AMP_CFG_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif
    localparam int EXP_WIN = 4 + RB;

    typedef struct {
        logic [15:0] word;
        int          len;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetb, req0, req1;
    logic [1:0]  cfg_addr0;
    logic [15:0] cfg_data0;
    logic        ncs0, sclk0, sdo0, busy0, done0, err0;
    logic        sdi0 = 1'b0;
    logic [0:0]  cfg_addr1;
    logic        ncs1, sclk1, sdo1, busy1, done1, err1;
    logic        sdi1 = 1'b0;
    logic [15:0] cfg_mem [4];

    assign cfg_data0 = cfg_mem[cfg_addr0];

    amp_config_sender #(.NUM_WORDS(4), .WORD_W(16), .CLK_DIV(2)) u_dut (
        .clk_in(clk), .resetb(resetb), .send_config_in(req0),
        .cfg_addr_out(cfg_addr0), .cfg_data_in(cfg_data0),
        .ncs_out(ncs0), .sclk_out(sclk0), .sdo_out(sdo0), .sdi_in(sdi0),
        .busy_out(busy0), .config_done_out(done0), .cfg_error_out(err0)
    );

    amp_config_sender #(.NUM_WORDS(1), .WORD_W(16), .CLK_DIV(1)) u_dut1 (
        .clk_in(clk), .resetb(resetb), .send_config_in(req1),
        .cfg_addr_out(cfg_addr1), .cfg_data_in(16'hC3A5),
        .ncs_out(ncs1), .sclk_out(sclk1), .sdo_out(sdo1), .sdi_in(sdi1),
        .busy_out(busy1), .config_done_out(done1), .cfg_error_out(err1)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    // Link monitor / amp model state for the main instance
    logic [15:0] word_a [8];
    int          len_a [8];
    int          gap_a [8];
    int          win_cnt, low_cnt, high_cnt, nbits, amp_idx, mode_err;
    int          last_rise, done_cyc;
    logic [15:0] rxw, amp_tx;
    logic [1:0]  fall_addr;
    logic        corrupt = 1'b0;
    logic        ncs0_p = 1'b1, sclk0_p = 1'b0, sdo0_p = 1'b0, done0_p = 1'b0;

    // Link monitor / state for the single-word instance
    int          win1 = 0, low1 = 0, len1 = -1, rise1 = 0, done1_cyc = 0;
    logic [15:0] rx1 = '0, w1 = '0;
    logic        ncs1_p = 1'b1, sclk1_p = 1'b0, done1_p = 1'b0;

    task automatic clear_mon();
        for (int i = 0; i < 8; i++) begin
            word_a[i] = 16'hDEAD;
            len_a[i]  = -1;
            gap_a[i]  = -1;
        end
        win_cnt = 0; low_cnt = 0; high_cnt = 0; nbits = 0;
        last_rise = 0; done_cyc = 0; fall_addr = 2'd0;
    endtask

    // Decode mode-0 SPI on the main instance and play the echoing amplifier
    always @(negedge clk) begin
        if (!ncs0 && ncs0_p) begin
            if (win_cnt > 0 && win_cnt <= 8) gap_a[win_cnt-1] = high_cnt;
            low_cnt = 0; nbits = 0; amp_idx = 0;
            sdi0 = amp_tx[15];
            fall_addr = cfg_addr0;
        end
        if (!ncs0) begin
            low_cnt++;
            if (sclk0 && !sclk0_p) begin
                rxw = {rxw[14:0], sdo0};
                nbits++;
            end
            if (!sclk0 && sclk0_p) begin
                amp_idx++;
                if (amp_idx < 16) sdi0 = amp_tx[15-amp_idx];
            end
            if (!ncs0_p && (sdo0 != sdo0_p) && !(sclk0_p && !sclk0)) mode_err++;
        end else begin
            high_cnt++;
            if (sclk0) mode_err++;
        end
        if (ncs0 && !ncs0_p) begin
            if (win_cnt < 8) begin
                word_a[win_cnt] = rxw;
                len_a[win_cnt]  = low_cnt;
            end
            amp_tx = (corrupt && win_cnt == 2) ? (rxw ^ 16'h0008) : rxw;
            win_cnt++;
            high_cnt  = 1;
            last_rise = cyc;
        end
        if (done0 && !done0_p) done_cyc = cyc;
        ncs0_p = ncs0; sclk0_p = sclk0; sdo0_p = sdo0; done0_p = done0;
    end

    // Decode the single-word instance
    always @(negedge clk) begin
        if (!ncs1 && ncs1_p) low1 = 0;
        if (!ncs1) begin
            low1++;
            if (sclk1 && !sclk1_p) rx1 = {rx1[14:0], sdo1};
        end
        if (ncs1 && !ncs1_p) begin
            if (win1 == 0) begin
                len1 = low1;
                w1   = rx1;
            end
            win1++;
            rise1 = cyc;
        end
        if (done1 && !done1_p) done1_cyc = cyc;
        ncs1_p = ncs1; sclk1_p = sclk1; done1_p = done1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done0(input string tag);
        int n = 0;
        while (!done0 && n < 1000) begin
            tick();
            n++;
        end
        chk(tag, 32'(done0), 32'd1);
    endtask

    vec_t vt [4];

    initial begin
        int n;
        vt[0] = '{word: 16'hA5A5, len: 64};
        vt[1] = '{word: 16'h0F0F, len: 64};
        vt[2] = '{word: 16'h1234, len: 64};
        vt[3] = '{word: 16'hFFFF, len: 64};
        for (int i = 0; i < 4; i++) cfg_mem[i] = vt[i].word;
        amp_tx = '0; rxw = '0; mode_err = 0;
        clear_mon();

        // Reset state
        resetb = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (3) tick();
        chk("rst_ncs",  32'(ncs0),  32'd1);
        chk("rst_sclk", 32'(sclk0), 32'd0);
        chk("rst_sdo",  32'(sdo0),  32'd0);
        chk("rst_addr", 32'(cfg_addr0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_err",  32'(err0),  32'd0);
        resetb = 1'b1;
        tick();

        // Full transfer: start latency, windows, gaps, decoded words
        clear_mon();
        req0 = 1'b1;
        tick();
        chk("c1_busy", 32'(busy0), 32'd1);
        chk("c1_ncs",  32'(ncs0),  32'd1);
        tick();
        chk("c2_ncs",  32'(ncs0),  32'd0);
        wait_done0("run1_done");
        tick();
        chk("run1_windows", 32'(win_cnt), 32'(EXP_WIN));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("run1_word%0d", i), 32'(word_a[i]), 32'(vt[i].word));
            chk($sformatf("run1_len%0d", i),  32'(len_a[i]),  32'(vt[i].len));
        end
        for (int i = 0; i < EXP_WIN - 1; i++)
            chk($sformatf("run1_gap%0d", i), 32'(gap_a[i]), 32'd4);
        if (RB != 0) chk("run1_flush_word", 32'(word_a[4]), 32'h0);
        chk("run1_done_lat", 32'(done_cyc - last_rise), 32'd4);
        chk("run1_busy",      32'(busy0), 32'd0);
        chk("run1_addr",      32'(cfg_addr0), 32'd3);
        chk("run1_last_addr", 32'(fall_addr), 32'd3);
        chk("run1_err",       32'(err0), 32'd0);

        // Done held, one-cycle drop returns to IDLE, re-raise re-runs from addr 0
        repeat (10) tick();
        chk("done_held", 32'(done0), 32'd1);
        req0 = 1'b0;
        tick();
        chk("drop_done", 32'(done0), 32'd0);
        chk("drop_busy", 32'(busy0), 32'd0);
        clear_mon();
        req0 = 1'b1;
        wait_done0("rerun_done");
        tick();
        chk("rerun_windows", 32'(win_cnt), 32'(EXP_WIN));
        chk("rerun_word0", 32'(word_a[0]), 32'hA5A5);
        chk("rerun_word3", 32'(word_a[3]), 32'hFFFF);

        // Request drops during word 1: finish it, no word 2, no done
        req0 = 1'b0;
        repeat (3) tick();
        clear_mon();
        req0 = 1'b1;
        n = 0;
        while (!(win_cnt == 1 && !ncs0) && n < 500) begin tick(); n++; end
        chk("abort_reach_w1", 32'(win_cnt == 1 && !ncs0), 32'd1);
        req0 = 1'b0;
        n = 0;
        while (busy0 && n < 500) begin tick(); n++; end
        chk("abort_idle", 32'(busy0), 32'd0);
        chk("abort_windows", 32'(win_cnt), 32'd2);
        chk("abort_word1", 32'(word_a[1]), 32'h0F0F);
        chk("abort_len1",  32'(len_a[1]),  32'd64);
        chk("abort_done",  32'(done0), 32'd0);
        repeat (150) tick();
        chk("abort_no_more", 32'(win_cnt), 32'd2);
        chk("abort_ncs", 32'(ncs0), 32'd1);

        // Reset during bit 7 of word 2, then held request restarts after reset
        clear_mon();
        req0 = 1'b1;
        n = 0;
        while (!(win_cnt == 2 && nbits == 7 && !ncs0) && n < 500) begin tick(); n++; end
        chk("rst_reach_bit7", 32'(win_cnt == 2 && nbits == 7), 32'd1);
        resetb = 1'b0;
        tick();
        chk("midrst_ncs",  32'(ncs0),  32'd1);
        chk("midrst_sclk", 32'(sclk0), 32'd0);
        chk("midrst_busy", 32'(busy0), 32'd0);
        chk("midrst_sdo",  32'(sdo0),  32'd0);
        chk("midrst_addr", 32'(cfg_addr0), 32'd0);
        tick();
        clear_mon();
        resetb = 1'b1;
        tick();
        chk("postrst_busy", 32'(busy0), 32'd1);
        wait_done0("postrst_done");
        tick();
        chk("postrst_windows", 32'(win_cnt), 32'(EXP_WIN));
        chk("postrst_word2", 32'(word_a[2]), 32'h1234);

`ifdef AMP_CFG_READBACK_EN
        // Corrupted echo of word 2 sets the sticky error; next start clears it
        req0 = 1'b0;
        tick();
        clear_mon();
        corrupt = 1'b1;
        req0 = 1'b1;
        wait_done0("rb_bad_done");
        tick();
        chk("rb_bad_err", 32'(err0), 32'd1);
        chk("rb_bad_windows", 32'(win_cnt), 32'd5);
        req0 = 1'b0;
        tick();
        chk("rb_err_sticky", 32'(err0), 32'd1);
        corrupt = 1'b0;
        clear_mon();
        req0 = 1'b1;
        tick();
        chk("rb_err_clear", 32'(err0), 32'd0);
        wait_done0("rb_good_done");
        tick();
        chk("rb_good_err", 32'(err0), 32'd0);
`else
        chk("no_rb_err", 32'(err0), 32'd0);
`endif
        chk("mode0_sdo_sclk", 32'(mode_err), 32'd0);

        // Single-word, CLK_DIV=1 instance
        req1 = 1'b1;
        n = 0;
        while (!done1 && n < 300) begin tick(); n++; end
        chk("s1_done", 32'(done1), 32'd1);
        tick();
        chk("s1_windows", 32'(win1), 32'(1 + RB));
        chk("s1_len",  32'(len1), 32'd32);
        chk("s1_word", 32'(w1), 32'hC3A5);
        chk("s1_done_lat", 32'(done1_cyc - rise1), 32'd2);
        chk("s1_addr", 32'(cfg_addr1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
